// File: rtl/sobel_window_if.sv
// Pixel-stream in / 3x3 window out bundle for the Sobel neighbourhood generator.
interface sobel_window_if #(
    parameter int unsigned CW = 11
) ();
    logic          in_valid;
    logic          in_sof;
    logic [7:0]    in_data;
    logic [7:0]    p0, p1, p2, p3, p5, p6, p7, p8;
    logic          out_valid;
    logic [CW-1:0] out_x;
    logic [CW-1:0] out_y;
    logic          frame_done;

    // Pixel source side
    modport master (
        output in_valid, in_sof, in_data,
        input  p0, p1, p2, p3, p5, p6, p7, p8, out_valid, out_x, out_y, frame_done
    );

    // Window generator side
    modport slave (
        input  in_valid, in_sof, in_data,
        output p0, p1, p2, p3, p5, p6, p7, p8, out_valid, out_x, out_y, frame_done
    );
endinterface

// File: rtl/sobel_window.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window.
// Emits one window per accepted pixel whose full neighbourhood lies inside the frame.
module sobel_window #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned CW    = 11
) (
    input logic           clk,
    input logic           rst,
    sobel_window_if.slave bus
);
    localparam int unsigned   XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CW-1:0] XLast = CW'(IMG_W - 1);
    localparam logic [CW-1:0] YLast = CW'(IMG_H - 1);

    // la holds row y-1, lb holds row y-2; never reset, stale data is gated by x/y >= 2
    logic [7:0] la_q [IMG_W];
    logic [7:0] lb_q [IMG_W];

    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [CW-1:0] cx, cy;
    logic [XW-1:0] rd_idx;
    logic [7:0]    top_new, mid_new;
    logic          accept;

    logic [7:0] p0_q, p1_q, p2_q, p3_q, p4_q, p5_q, p6_q, p7_q, p8_q;
    logic [7:0] p0_d, p1_d, p2_d, p3_d, p4_d, p5_d, p6_d, p7_d, p8_d;
    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] out_x_q, out_x_d, out_y_q, out_y_d;
    logic          frame_done_q, frame_done_d;

    assign accept = rst & bus.in_valid;

    // Effective position of the incoming pixel (sof forces a frame restart) and buffer reads
    always_comb begin
        cx      = bus.in_sof ? '0 : x_q;
        cy      = bus.in_sof ? '0 : y_q;
        rd_idx  = cx[XW-1:0];
        top_new = lb_q[rd_idx];
        mid_new = la_q[rd_idx];
    end

    // Line buffer update: column moves up one row
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_q[rd_idx] <= la_q[rd_idx];
            la_q[rd_idx] <= bus.in_data;
        end
    end

    // Next-state: window shift, coordinate counters and output strobes
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        p0_d         = p0_q;
        p1_d         = p1_q;
        p2_d         = p2_q;
        p3_d         = p3_q;
        p4_d         = p4_q;
        p5_d         = p5_q;
        p6_d         = p6_q;
        p7_d         = p7_q;
        p8_d         = p8_q;
        out_valid_d  = 1'b0;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        frame_done_d = 1'b0;
        if (accept) begin
            p0_d = p1_q;
            p1_d = p2_q;
            p2_d = top_new;
            p3_d = p4_q;
            p4_d = p5_q;
            p5_d = mid_new;
            p6_d = p7_q;
            p7_d = p8_q;
            p8_d = bus.in_data;
            if (cx >= CW'(2) && cy >= CW'(2)) begin
                out_valid_d = 1'b1;
                out_x_d     = cx - CW'(1);
                out_y_d     = cy - CW'(1);
            end
            if (cx == XLast) begin
                x_d = '0;
                if (cy == YLast) begin
                    y_d          = '0;
                    frame_done_d = 1'b1;
                end else begin
                    y_d = cy + CW'(1);
                end
            end else begin
                x_d = cx + CW'(1);
                y_d = cy;
            end
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q          <= '0;
            y_q          <= '0;
            p0_q         <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            p3_q         <= '0;
            p4_q         <= '0;
            p5_q         <= '0;
            p6_q         <= '0;
            p7_q         <= '0;
            p8_q         <= '0;
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            p0_q         <= p0_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            p3_q         <= p3_d;
            p4_q         <= p4_d;
            p5_q         <= p5_d;
            p6_q         <= p6_d;
            p7_q         <= p7_d;
            p8_q         <= p8_d;
            out_valid_q  <= out_valid_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.p0         = p0_q;
    assign bus.p1         = p1_q;
    assign bus.p2         = p2_q;
    assign bus.p3         = p3_q;
    assign bus.p5         = p5_q;
    assign bus.p6         = p6_q;
    assign bus.p7         = p7_q;
    assign bus.p8         = p8_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_x      = out_x_q;
    assign bus.out_y      = out_y_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_sobel_window.sv
// Bench for sobel_window: a 4x4 instance and a 5x5 instance, a frame-image model per
// instance that predicts every output cycle, plus literal window expectations.
module tb_sobel_window;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sobel_window_if #(.CW(11)) bus4 ();
    sobel_window_if #(.CW(11)) bus5 ();

    sobel_window #(.IMG_W(4), .IMG_H(4), .CW(11)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    sobel_window #(.IMG_W(5), .IMG_H(5), .CW(11)) u_dut5 (.clk(clk), .rst(rst), .bus(bus5));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Per-instance views of the interface signals
    logic        iv   [2];
    logic        isof [2];
    logic [7:0]  idat [2];
    logic        ov   [2];
    logic        ofd  [2];
    logic [10:0] ox   [2];
    logic [10:0] oy   [2];
    logic [63:0] dwin [2];

    always_comb begin
        iv[0]   = bus4.in_valid;
        isof[0] = bus4.in_sof;
        idat[0] = bus4.in_data;
        ov[0]   = bus4.out_valid;
        ofd[0]  = bus4.frame_done;
        ox[0]   = bus4.out_x;
        oy[0]   = bus4.out_y;
        dwin[0] = {bus4.p0, bus4.p1, bus4.p2, bus4.p3, bus4.p5, bus4.p6, bus4.p7, bus4.p8};
        iv[1]   = bus5.in_valid;
        isof[1] = bus5.in_sof;
        idat[1] = bus5.in_data;
        ov[1]   = bus5.out_valid;
        ofd[1]  = bus5.frame_done;
        ox[1]   = bus5.out_x;
        oy[1]   = bus5.out_y;
        dwin[1] = {bus5.p0, bus5.p1, bus5.p2, bus5.p3, bus5.p5, bus5.p6, bus5.p7, bus5.p8};
    end

    // Model: remember every pixel of the current frame by coordinate, derive windows from it
    logic [7:0]  img [2][5][5];
    int          mx [2] = '{0, 0};
    int          my [2] = '{0, 0};
    logic        exp_v [2] = '{1'b0, 1'b0};
    logic        exp_fd [2] = '{1'b0, 1'b0};
    int          exp_x [2] = '{0, 0};
    int          exp_y [2] = '{0, 0};
    logic [63:0] exp_w [2];
    int          mcx, mcy, dim;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            dim = (k == 0) ? 4 : 5;
            if (!rst) begin
                mx[k] = 0; my[k] = 0; exp_v[k] = 1'b0; exp_fd[k] = 1'b0;
                exp_x[k] = 0; exp_y[k] = 0;
            end else if (iv[k]) begin
                mcx = isof[k] ? 0 : mx[k];
                mcy = isof[k] ? 0 : my[k];
                img[k][mcy][mcx] = idat[k];
                exp_fd[k] = 1'b0;
                exp_v[k]  = (mcx >= 2 && mcy >= 2);
                if (exp_v[k]) begin
                    exp_x[k] = mcx - 1;
                    exp_y[k] = mcy - 1;
                    exp_w[k] = {img[k][mcy-2][mcx-2], img[k][mcy-2][mcx-1], img[k][mcy-2][mcx],
                                img[k][mcy-1][mcx-2], img[k][mcy-1][mcx],
                                img[k][mcy][mcx-2], img[k][mcy][mcx-1], img[k][mcy][mcx]};
                end
                if (mcx == dim - 1) begin
                    mx[k] = 0;
                    if (mcy == dim - 1) begin
                        my[k] = 0;
                        exp_fd[k] = 1'b1;
                    end else begin
                        my[k] = mcy + 1;
                    end
                end else begin
                    mx[k] = mcx + 1;
                    my[k] = mcy;
                end
            end else begin
                exp_v[k]  = 1'b0;
                exp_fd[k] = 1'b0;
            end
        end
    end

    // Compare every cycle once reset has been applied
    bit chk_en = 1'b0;
    int nv [2] = '{0, 0};
    int nf [2] = '{0, 0};

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("dut%0d out_valid", k), 64'(ov[k]), 64'(exp_v[k]));
                check($sformatf("dut%0d frame_done", k), 64'(ofd[k]), 64'(exp_fd[k]));
                check($sformatf("dut%0d out_x", k), 64'(ox[k]), 64'(exp_x[k]));
                check($sformatf("dut%0d out_y", k), 64'(oy[k]), 64'(exp_y[k]));
                if (exp_v[k]) check($sformatf("dut%0d window", k), dwin[k], exp_w[k]);
                nv[k] += int'(ov[k]);
                nf[k] += int'(ofd[k]);
            end
        end
    end

    // Drive one cycle on instance k; returns 1 time unit after the sampling edge
    task automatic px(input int k, input logic v, input logic s, input logic [7:0] d);
        if (k == 0) begin
            bus4.in_valid = v; bus4.in_sof = s; bus4.in_data = d;
        end else begin
            bus5.in_valid = v; bus5.in_sof = s; bus5.in_data = d;
        end
        @(posedge clk);
        #1;
        if (k == 0) begin
            bus4.in_valid = 1'b0; bus4.in_sof = 1'b0;
        end else begin
            bus5.in_valid = 1'b0; bus5.in_sof = 1'b0;
        end
    endtask

    int n0, f0;

    initial begin
        bus4.in_valid = 1'b1; bus4.in_sof = 1'b0; bus4.in_data = 8'hAA;
        bus5.in_valid = 1'b1; bus5.in_sof = 1'b0; bus5.in_data = 8'h55;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset window4", dwin[0], 64'h0);
        check("reset valid4", 64'(ov[0]), 64'h0);
        check("reset x4", 64'(ox[0]), 64'h0);
        check("reset y4", 64'(oy[0]), 64'h0);
        check("reset done4", 64'(ofd[0]), 64'h0);
        check("reset window5", dwin[1], 64'h0);
        bus4.in_valid = 1'b0;
        bus5.in_valid = 1'b0;
        rst = 1'b1;
        px(0, 1'b0, 1'b0, 8'h00);

        // Continuous 4x4 frame
        n0 = nv[0]; f0 = nf[0];
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                px(0, 1'b1, 1'b0, 8'(16 * y + x));
                if (y == 2 && x == 1) check("no window before (2,2)", 64'(ov[0]), 64'h0);
                if (y == 2 && x == 2) begin
                    check("first window", dwin[0], 64'h00010210_12202122);
                    check("first valid", 64'(ov[0]), 64'h1);
                    check("first coords", {32'(ox[0]), 32'(oy[0])}, {32'd1, 32'd1});
                end
                if (y == 3 && x == 3) begin
                    check("last window", dwin[0], 64'h11121321_23313233);
                    check("last coords", {32'(ox[0]), 32'(oy[0])}, {32'd2, 32'd2});
                    check("last frame_done", 64'(ofd[0]), 64'h1);
                end
            end
        end
        px(0, 1'b0, 1'b0, 8'h00);
        check("frame1 strobes", 64'(nv[0] - n0), 64'd4);
        check("frame1 done count", 64'(nf[0] - f0), 64'd1);

        // Same image with randomly gapped input
        n0 = nv[0];
        for (int i = 0; i < 16; i++) begin
            while ($urandom_range(1, 0) == 0) px(0, 1'b0, 1'b0, 8'hEE);
            px(0, 1'b1, 1'b0, 8'(16 * (i / 4) + (i % 4)));
        end
        px(0, 1'b0, 1'b0, 8'h00);
        check("gapped strobes", 64'(nv[0] - n0), 64'd4);

        // Back-to-back frames, second inverted, no sof
        n0 = nv[0]; f0 = nf[0];
        for (int i = 0; i < 16; i++) px(0, 1'b1, 1'b0, 8'(16 * (i / 4) + (i % 4)));
        for (int i = 0; i < 16; i++) begin
            px(0, 1'b1, 1'b0, 8'(8'hFF - (16 * (i / 4) + (i % 4))));
            if (i == 10) begin
                check("frame2 first window", dwin[0], 64'hFFFEFDEF_EDDFDEDD);
                check("frame2 first coords", {32'(ox[0]), 32'(oy[0])}, {32'd1, 32'd1});
            end
        end
        px(0, 1'b0, 1'b0, 8'h00);
        check("b2b strobes", 64'(nv[0] - n0), 64'd8);
        check("b2b done count", 64'(nf[0] - f0), 64'd2);

        // sof at pixel 6 aborts the frame
        n0 = nv[0]; f0 = nf[0];
        for (int i = 0; i < 6; i++) px(0, 1'b1, 1'b0, 8'(8'h80 + i));
        for (int i = 0; i < 16; i++) begin
            px(0, 1'b1, (i == 0), 8'(16 * (i / 4) + (i % 4)));
            if (i == 10) check("sof first window", dwin[0], 64'h00010210_12202122);
        end
        px(0, 1'b0, 1'b0, 8'h00);
        check("sof strobes", 64'(nv[0] - n0), 64'd4);
        check("sof done count", 64'(nf[0] - f0), 64'd1);

        // 5x5: reset after pixel (2,3), then a clean frame
        for (int i = 0; i < 18; i++) px(1, 1'b1, 1'b0, 8'(16 * (i / 5) + (i % 5)));
        rst = 1'b0;
        px(1, 1'b1, 1'b0, 8'h77);
        px(1, 1'b1, 1'b0, 8'h77);
        check("mid reset window5", dwin[1], 64'h0);
        check("mid reset valid5", 64'(ov[1]), 64'h0);
        rst = 1'b1;
        n0 = nv[1]; f0 = nf[1];
        for (int i = 0; i < 25; i++) begin
            px(1, 1'b1, 1'b0, 8'(16 * (i / 5) + (i % 5) + 3));
            if (i == 12) begin
                check("5x5 first window", dwin[1], 64'h03040513_15232425);
                check("5x5 first coords", {32'(ox[1]), 32'(oy[1])}, {32'd1, 32'd1});
            end
        end
        px(1, 1'b0, 1'b0, 8'h00);
        check("5x5 strobes", 64'(nv[1] - n0), 64'd9);
        check("5x5 done count", 64'(nf[1] - f0), 64'd1);

        px(0, 1'b0, 1'b0, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
